// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory arbiter.
// Owner and state encodings, NOP word, counter sizing helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection between fetch and load/store requesters.
// LS wins ties unless the starvation counter has hit its limit.
module mem_arb_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = cnt_width(STARVE_LIMIT)
) (
    input  logic          if_req,
    input  logic          ls_req,
    input  logic [CW-1:0] starve_cnt,
    output logic          grant,
    output owner_t        winner
);

    logic force_if;
    logic ls_win;

    assign force_if = (STARVE_LIMIT != 0) &&
                      (starve_cnt == CW'(STARVE_LIMIT));
    assign ls_win   = ls_req && !(if_req && force_if);
    assign grant    = if_req || ls_req;
    assign winner   = ls_win ? OWN_LS : OWN_IF;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the IF and LS paths.
// Define MEM_ARB_TIMEOUT_EN to add the wait timeout and err pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wstrb,
    output logic        ls_gnt,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
`ifdef MEM_ARB_TIMEOUT_EN
    input  logic [31:0] mem_rdata,
    output logic        err
`else
    input  logic [31:0] mem_rdata
`endif
);

    localparam int CW = cnt_width(STARVE_LIMIT);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] starve_cnt;
    logic          grant;
    owner_t        winner;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [3:0]    cap_wstrb;
    logic          cap_we;

    mem_arb_sel #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CW          (CW)
    ) u_sel (
        .if_req    (if_req),
        .ls_req    (ls_req),
        .starve_cnt(starve_cnt),
        .grant     (grant),
        .winner    (winner)
    );

    // Grants are gated by reset so every output reads 0 while it is held.
    assign if_gnt = !reset && (state == IDLE) && grant && (winner == OWN_IF);
    assign ls_gnt = !reset && (state == IDLE) && grant && (winner == OWN_LS);

    assign busy      = (state != IDLE);
    assign done      = busy && (mem_ready || timeout);
    assign mem_req   = busy;
    assign mem_we    = cap_we;
    assign mem_addr  = cap_addr & ~32'h3;
    assign mem_wdata = cap_wdata;
    assign mem_wstrb = cap_we ? cap_wstrb : 4'h0;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wait_cnt;

    assign timeout = busy && !mem_ready &&
                     (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timeout;
            if (if_gnt || ls_gnt) begin
                wait_cnt <= '0;
            end else if (busy && !mem_ready) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    state_n = (winner == OWN_LS) ? BUSY_LS : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            cap_we    <= 1'b0;
        end else if (if_gnt) begin
            cap_addr  <= if_addr;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            cap_we    <= 1'b0;
        end else if (ls_gnt) begin
            cap_addr  <= ls_addr;
            cap_wdata <= ls_wdata;
            cap_wstrb <= ls_wstrb;
            cap_we    <= ls_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (ls_gnt) begin
            if (!if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    // A timed-out access still completes, returning a harmless word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            if (done && (state == BUSY_IF)) begin
                if_valid <= 1'b1;
                if_rdata <= timeout ? NOP : mem_rdata;
            end
            if (done && (state == BUSY_LS)) begin
                ls_valid <= 1'b1;
                ls_rdata <= (timeout || cap_we) ? 32'h0 : mem_rdata;
            end
        end
    end

endmodule
